// File: rtl/vga_sync_generator_pkg.sv
// ============================================================================
// Module      : vga_sync_generator_pkg
// Description : Shared VGA 640x480 timing constants, counter types and
//               window helper for the sync generator, pixel pipeline and
//               frame buffer reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_sync_generator_pkg;

    localparam int c_H_VISIBLE = 640;
    localparam int c_H_FRONT   = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BACK    = 48;
    localparam int c_V_VISIBLE = 480;
    localparam int c_V_FRONT   = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BACK    = 33;

    localparam int c_H_TOTAL    = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;
    localparam int c_V_TOTAL    = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;
    localparam int c_HS_START   = c_H_VISIBLE + c_H_FRONT;
    localparam int c_HS_END     = c_HS_START + c_H_SYNC;
    localparam int c_VS_START   = c_V_VISIBLE + c_V_FRONT;
    localparam int c_VS_END     = c_VS_START + c_V_SYNC;

    localparam int c_CNT_W = 10;

    typedef logic [c_CNT_W-1:0] count_t;
    // One extra bit so an exclusive upper bound of 1024 stays representable.
    typedef logic [c_CNT_W:0]   bound_t;

    function automatic logic in_window(input count_t pos, input bound_t lo, input bound_t hi);
        return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_generator.sv
// ============================================================================
// Module      : vga_sync_generator
// Description : Pixel/line counters with registered active-low syncs,
//               visible-region flag and one-clk frame start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_generator
    import vga_sync_generator_pkg::*;
#(
    parameter int H_VISIBLE = c_H_VISIBLE,
    parameter int H_FRONT   = c_H_FRONT,
    parameter int H_SYNC    = c_H_SYNC,
    parameter int H_BACK    = c_H_BACK,
    parameter int V_VISIBLE = c_V_VISIBLE,
    parameter int V_FRONT   = c_V_FRONT,
    parameter int V_SYNC    = c_V_SYNC,
    parameter int V_BACK    = c_V_BACK
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       pixel_clock_pulse,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);

    localparam int     c_H_SUM  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int     c_V_SUM  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam count_t c_H_LAST = count_t'(c_H_SUM - 1);
    localparam count_t c_V_LAST = count_t'(c_V_SUM - 1);
    localparam bound_t c_HS_LO  = bound_t'(H_VISIBLE + H_FRONT);
    localparam bound_t c_HS_HI  = bound_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam bound_t c_VS_LO  = bound_t'(V_VISIBLE + V_FRONT);
    localparam bound_t c_VS_HI  = bound_t'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam bound_t c_H_VIS  = bound_t'(H_VISIBLE);
    localparam bound_t c_V_VIS  = bound_t'(V_VISIBLE);

    generate
        if (c_H_SUM > 1024 || c_V_SUM > 1024) begin : g_bad_timing
            $error("vga_sync_generator: H/V totals must not exceed 1024");
        end
    endgenerate

    count_t h_q, h_d;
    count_t v_q, v_d;
    logic   hsync_q, vsync_q, video_on_q, frame_start_q;
    logic   w_h_end, w_v_end;

    always_comb begin
        w_h_end = (h_q == c_H_LAST);
        w_v_end = (v_q == c_V_LAST);
        h_d     = h_q;
        v_d     = v_q;
        if (pixel_clock_pulse) begin
            if (w_h_end) begin
                h_d = '0;
                v_d = w_v_end ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Decoded outputs are taken from the next-state counts so that they
    // land in the same cycle as the counter values they describe.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= ~in_window(h_d, c_HS_LO, c_HS_HI);
            vsync_q       <= ~in_window(v_d, c_VS_LO, c_VS_HI);
            video_on_q    <= ({1'b0, h_d} < c_H_VIS) && ({1'b0, v_d} < c_V_VIS);
            frame_start_q <= pixel_clock_pulse & w_h_end & w_v_end;
        end
    end

    assign h_count     = h_q;
    assign v_count     = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_generator.sv
// ============================================================================
// Module      : tb_vga_sync_generator
// Description : Directed bench for a default-timing and a reduced-timing
//               (15x8 total) sync generator sharing clock, reset and pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_generator;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       pulse;

    logic [9:0] d_h, d_v, s_h, s_v;
    logic       d_hs, d_vs, d_vid, d_fs;
    logic       s_hs, s_vs, s_vid, s_fs;

    int n_checks = 0;
    int n_errors = 0;

    // Reference positions, tracked from the stimulus alone.
    int   mh_d, mv_d, mh_s, mv_s;
    logic mfs_d, mfs_s;

    always #5 clk = ~clk;

    vga_sync_generator dut_d (
        .clk               (clk),
        .reset_p           (reset_p),
        .pixel_clock_pulse (pulse),
        .h_count           (d_h),
        .v_count           (d_v),
        .hsync             (d_hs),
        .vsync             (d_vs),
        .video_on          (d_vid),
        .frame_start       (d_fs)
    );

    // Small timing: H 8+2+3+2=15 (sync 10..12), V 4+1+2+1=8 (sync 5..6).
    vga_sync_generator #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
    ) dut_s (
        .clk               (clk),
        .reset_p           (reset_p),
        .pixel_clock_pulse (pulse),
        .h_count           (s_h),
        .v_count           (s_v),
        .hsync             (s_hs),
        .vsync             (s_vs),
        .video_on          (s_vid),
        .frame_start       (s_fs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("d_h",   32'(d_h), 32'(mh_d));
        check("d_v",   32'(d_v), 32'(mv_d));
        check("d_hs",  32'(d_hs), 32'(!(mh_d >= 656 && mh_d <= 751)));
        check("d_vs",  32'(d_vs), 32'(!(mv_d >= 490 && mv_d <= 491)));
        check("d_vid", 32'(d_vid), 32'(mh_d < 640 && mv_d < 480));
        check("d_fs",  32'(d_fs), 32'(mfs_d));
        check("s_h",   32'(s_h), 32'(mh_s));
        check("s_v",   32'(s_v), 32'(mv_s));
        check("s_hs",  32'(s_hs), 32'(!(mh_s >= 10 && mh_s <= 12)));
        check("s_vs",  32'(s_vs), 32'(!(mv_s >= 5 && mv_s <= 6)));
        check("s_vid", 32'(s_vid), 32'(mh_s < 8 && mv_s < 4));
        check("s_fs",  32'(s_fs), 32'(mfs_s));
    endtask

    task automatic tick(input logic rst, input logic p);
        reset_p = rst;
        pulse   = p;
        @(posedge clk);
        #1;
        if (rst) begin
            mh_d = 0; mv_d = 0; mfs_d = 1'b0;
            mh_s = 0; mv_s = 0; mfs_s = 1'b0;
        end else if (p) begin
            mfs_d = (mh_d == 799 && mv_d == 524);
            mfs_s = (mh_s == 14 && mv_s == 7);
            if (mh_d == 799) begin
                mh_d = 0;
                mv_d = (mv_d == 524) ? 0 : mv_d + 1;
            end else begin
                mh_d++;
            end
            if (mh_s == 14) begin
                mh_s = 0;
                mv_s = (mv_s == 7) ? 0 : mv_s + 1;
            end else begin
                mh_s++;
            end
        end else begin
            mfs_d = 1'b0;
            mfs_s = 1'b0;
        end
        check_all();
    endtask

    initial begin
        int hs_cnt, hs_first, vid_cnt, fs_cnt, vs_cnt;
        reset_p = 1'b1;
        pulse   = 1'b0;
        mh_d = 0; mv_d = 0; mfs_d = 1'b0;
        mh_s = 0; mv_s = 0; mfs_s = 1'b0;

        // Reset wins over a pulse.
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check("rst_h",   32'(d_h), 0);
        check("rst_v",   32'(d_v), 0);
        check("rst_hs",  32'(d_hs), 1);
        check("rst_vs",  32'(d_vs), 1);
        check("rst_vid", 32'(d_vid), 1);
        check("rst_fs",  32'(d_fs), 0);

        // One default line with a pulse every 4th clk.
        hs_cnt = 0; hs_first = -1; vid_cnt = 0;
        for (int i = 0; i < 3200; i++) begin
            tick(1'b0, (i % 4) == 3);
            if ((i % 4) == 3) begin
                if (!d_hs) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(d_h);
                end
                if (d_vid) vid_cnt++;
            end
        end
        check("line_h_wrap",  32'(d_h), 0);
        check("line_v_inc",   32'(d_v), 1);
        check("line_hs_cnt",  32'(hs_cnt), 96);
        check("line_hs_first", 32'(hs_first), 656);
        check("line_vid_cnt", 32'(vid_cnt), 640);

        // Pause mid-line at h=300.
        tick(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) tick(1'b0, 1'b1);
        check("pause_h_at", 32'(d_h), 300);
        for (int i = 0; i < 1000; i++) tick(1'b0, 1'b0);
        check("pause_h_hold", 32'(d_h), 300);
        tick(1'b0, 1'b1);
        check("pause_resume", 32'(d_h), 301);

        // Mid-line reset at h=700 inside hsync.
        tick(1'b1, 1'b0);
        for (int i = 0; i < 700; i++) tick(1'b0, 1'b1);
        check("mr_hs_low", 32'(d_hs), 0);
        tick(1'b1, 1'b0);
        check("mr_h0",  32'(d_h), 0);
        check("mr_hs1", 32'(d_hs), 1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("mr_h1", 32'(d_h), 1);
        check("mr_v0", 32'(d_v), 0);

        // Small core: reset at h=12, v=6 (both syncs low).
        tick(1'b1, 1'b0);
        for (int i = 0; i < 102; i++) tick(1'b0, 1'b1);
        check("smr_h",  32'(s_h), 12);
        check("smr_v",  32'(s_v), 6);
        check("smr_hs", 32'(s_hs), 0);
        check("smr_vs", 32'(s_vs), 0);
        tick(1'b1, 1'b1);
        check("smr_rst_h",  32'(s_h), 0);
        check("smr_rst_vs", 32'(s_vs), 1);
        check("smr_rst_vid", 32'(s_vid), 1);
        tick(1'b0, 1'b1);
        check("smr_h1", 32'(s_h), 1);
        check("smr_v0", 32'(s_v), 0);

        // Small core: two full frames with pulse tied high.
        tick(1'b1, 1'b0);
        hs_cnt = 0; vid_cnt = 0; fs_cnt = 0; vs_cnt = 0;
        for (int i = 0; i < 240; i++) begin
            tick(1'b0, 1'b1);
            if (!s_hs) hs_cnt++;
            if (!s_vs) vs_cnt++;
            if (s_vid) vid_cnt++;
            if (s_fs)  fs_cnt++;
            if (i == 118) begin
                check("wrap_pre_h", 32'(s_h), 14);
                check("wrap_pre_v", 32'(s_v), 7);
                check("wrap_pre_fs", 32'(s_fs), 0);
            end
            if (i == 119) begin
                check("wrap_h", 32'(s_h), 0);
                check("wrap_v", 32'(s_v), 0);
                check("wrap_fs", 32'(s_fs), 1);
            end
            if (i == 120) begin
                check("wrap_post_fs", 32'(s_fs), 0);
                check("wrap_post_h",  32'(s_h), 1);
            end
        end
        check("frm_vid_cnt", 32'(vid_cnt), 64);
        check("frm_fs_cnt",  32'(fs_cnt), 2);
        check("frm_vs_cnt",  32'(vs_cnt), 60);
        check("frm_hs_cnt",  32'(hs_cnt), 48);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_sync_generator.md
VGA_SYNC_GENERATOR -- requirements
Module: vga_sync_generator

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, system clock (100 MHz); the block's only clock.
REQ-010 SHALL have port reset_p, input, 1, reset; synchronous and active-high.
REQ-011 SHALL have port pixel_clock_pulse, input, 1, one-clk-wide pixel enable from the pixel clock generator (1 in 4 clks at defaults).
REQ-012 SHALL have port h_count, output, 10, current pixel column, 0..H_TOTAL-1.
REQ-013 SHALL have port v_count, output, 10, current line, 0..V_TOTAL-1.
REQ-014 SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-015 SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-016 SHALL have port video_on, output, 1, high when (h_count, v_count) lies in the visible region.
REQ-017 SHALL have port frame_start, output, 1, one-clk pulse when the counters wrap to (0,0).

Function
REQ-018 H_TOTAL = sum of H_* (800 at defaults); V_TOTAL = sum of V_* (525 at defaults).
REQ-019 Counters SHALL advance only on clk edges where pixel_clock_pulse=1, and SHALL hold otherwise.
REQ-020 h_count SHALL increment by 1 per pulse and wrap from H_TOTAL-1 to 0.
REQ-021 v_count SHALL increment only on a pulse where h_count=H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0 on that same pulse.
REQ-022 hsync SHALL be 0 iff H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC (656..751 at defaults).
REQ-023 vsync SHALL be 0 iff V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC (490..491 at defaults).
REQ-024 video_on SHALL be 1 iff h_count < H_VISIBLE and v_count < V_VISIBLE.
REQ-025 hsync, vsync and video_on SHALL be registered, and SHALL be aligned with the counter values on the same clk cycle (computed from next-state counter values); no combinational path from pixel_clock_pulse to any output.
REQ-026 frame_start SHALL be 1 for exactly one clk, namely the cycle after the edge on which both counters wrap to 0; it SHALL be 0 at all other times, including after reset.
REQ-027 If pixel_clock_pulse is held high continuously, the block SHALL advance one pixel per clk with no skipped or repeated counts.
REQ-028 Counter arithmetic SHALL be 10-bit unsigned; parameters SHALL satisfy H_TOTAL, V_TOTAL <= 1024.

Reset
REQ-029 On a clk edge with reset_p=1: h_count=0, v_count=0, hsync=1, vsync=1, video_on=1, frame_start=0, regardless of pixel_clock_pulse.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; counting SHALL resume from (0,0) on the first pulse after reset_p deasserts, that pulse giving h_count=1.

Structure
REQ-031 The timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL, sync start/end positions) SHALL live in a shared VGA timing package/include, for reuse by the pixel pipeline and frame buffer reader.
REQ-032 The block SHALL be a single module with no sub-modules; it is instantiated alongside pixel_clock_generator, with that block's pixel_clock_pulse output wired to its input.

Verification
REQ-033 Reset, then 3200 clks with pulse every 4th clk: h_count=800 steps 0..799 then 0; v_count=1 after the wrap.
REQ-034 Free-running pulses: hsync low for exactly 96 pulses per line, starting at h_count=656; vsync low for exactly 2 lines, starting at v_count=490.
REQ-035 Full frame: video_on high for exactly 640x480=307200 pulses; frame_start pulses once per 420000 pulses (800x525), one clk wide.
REQ-036 pixel_clock_pulse held 0 for 1000 clks mid-line (h_count=300): all outputs hold, and counting resumes at 301.
REQ-037 Assert reset_p for one clk at h_count=700, v_count=491: next cycle all outputs are at reset values; the following pulse gives h_count=1, v_count=0.
REQ-038 pixel_clock_pulse tied high: outputs at h_count=799, v_count=524 and then (0,0) appear on consecutive clks, and frame_start=1 on the clk after the wrap edge.
